// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: a Moore FSM that sequences fetch,
// decode, memory, execute and write-back. It adds a bounded wait on memory
// handshakes and keeps a running count of retired instructions.
module multicycle_control #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        mem_error,
    output logic        illegal_op,
    output logic        instr_retired,
    output logic [31:0] retire_count
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
        R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_WB
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_count;
    logic       is_store;
    logic       waiting;
    logic       timeout;

    assign waiting = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
    assign timeout = waiting && !mem_ready && (wait_count == WAIT_LIMIT);

    // State register; reset parks the machine in FETCH without a clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= FETCH;
        else
            state <= state_next;
    end

    // Counts stalled memory cycles; restarts on any state change or abort.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            wait_count <= '0;
        else if ((state_next != state) || timeout)
            wait_count <= '0;
        else if (waiting && !mem_ready)
            wait_count <= wait_count + 8'd1;
    end

    // Remembers load vs store as decode hands off, since the opcode may change afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            is_store <= 1'b0;
        else if ((state == DECODE) && (state_next == MEM_ADDR))
            is_store <= (opcode == OP_SW);
    end

    // Retired-instruction counter, wrapping naturally at 32 bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            retire_count <= '0;
        else if (instr_retired)
            retire_count <= retire_count + 32'd1;
    end

    // Next-state and control decode; everything is held at zero while reset is low.
    always_comb begin
        state_next    = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        mem_error     = 1'b0;
        illegal_op    = 1'b0;
        instr_retired = 1'b0;
        if (reset) begin
            mem_error = timeout;
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW: state_next = MEM_ADDR;
                        OP_RTYPE:     state_next = R_EXEC;
                        OP_BEQ:       state_next = BRANCH;
                        OP_J:         state_next = JUMP;
                        OP_ADDI:      state_next = I_EXEC;
                        default: begin
                            illegal_op = 1'b1;
                            state_next = FETCH;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    state_next = is_store ? MEM_WRITE : MEM_READ;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready)
                        state_next = MEM_WB;
                    else if (timeout)
                        state_next = FETCH;
                end
                MEM_WB: begin
                    reg_write     = 1'b1;
                    mem_to_reg    = 1'b1;
                    instr_retired = 1'b1;
                    state_next    = FETCH;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) begin
                        instr_retired = 1'b1;
                        state_next    = FETCH;
                    end else if (timeout) begin
                        state_next = FETCH;
                    end
                end
                R_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 2'b10;
                    state_next = R_WB;
                end
                R_WB: begin
                    reg_dst       = 1'b1;
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                    state_next    = FETCH;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_retired = 1'b1;
                    state_next    = FETCH;
                end
                JUMP: begin
                    pc_write      = 1'b1;
                    pc_source     = 2'b10;
                    instr_retired = 1'b1;
                    state_next    = FETCH;
                end
                I_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    state_next = I_WB;
                end
                I_WB: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                    state_next    = FETCH;
                end
                default: state_next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed cases followed by random
// instruction streams. Expected control values come from an instruction-level
// model that expands each instruction into its phases.
module tb_multicycle_control;

    localparam int MAX_WAIT = 15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       mem_error;
        logic       illegal_op;
        logic       instr_retired;
    } outs_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        reg_dst, reg_write, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic        mem_error, illegal_op, instr_retired;
    logic [31:0] retire_count;
    outs_t       observed;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_count = '0;
    int          cur_cycles = 0;
    int          seq_cycles = 0;

    multicycle_control #(.MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .mem_error(mem_error), .illegal_op(illegal_op),
        .instr_retired(instr_retired), .retire_count(retire_count)
    );

    assign observed = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                       pc_source, mem_error, illegal_op, instr_retired};

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Control values each phase must show, taken directly from the phase descriptions.
    function automatic outs_t phase_out(input string ph, input logic rdy);
        outs_t o;
        o = '0;
        if (ph == "FETCH") begin
            o.mem_read = 1'b1; o.alu_src_b = 2'b01;
            if (rdy) begin o.ir_write = 1'b1; o.pc_write = 1'b1; end
        end else if (ph == "DECODE") begin
            o.alu_src_b = 2'b11;
        end else if (ph == "MEM_ADDR") begin
            o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        end else if (ph == "MEM_READ") begin
            o.mem_read = 1'b1; o.i_or_d = 1'b1;
        end else if (ph == "MEM_WB") begin
            o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_retired = 1'b1;
        end else if (ph == "MEM_WRITE") begin
            o.mem_write = 1'b1; o.i_or_d = 1'b1; o.instr_retired = rdy;
        end else if (ph == "R_EXEC") begin
            o.alu_src_a = 1'b1; o.alu_op = 2'b10;
        end else if (ph == "R_WB") begin
            o.reg_dst = 1'b1; o.reg_write = 1'b1; o.instr_retired = 1'b1;
        end else if (ph == "BRANCH") begin
            o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1;
            o.pc_source = 2'b01; o.instr_retired = 1'b1;
        end else if (ph == "JUMP") begin
            o.pc_write = 1'b1; o.pc_source = 2'b10; o.instr_retired = 1'b1;
        end else if (ph == "I_EXEC") begin
            o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        end else if (ph == "I_WB") begin
            o.reg_write = 1'b1; o.instr_retired = 1'b1;
        end
        return o;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    // Zero-wait instruction lengths in cycles.
    function automatic int base_latency(input logic [5:0] op);
        if (op == OP_LW) return 5;
        if (op == OP_BEQ || op == OP_J) return 3;
        return 4;
    endfunction

    task automatic applyStimulus(input logic rdy, input logic [5:0] op);
        mem_ready = rdy;
        opcode    = op;
    endtask

    task automatic checkOutput(input string tag, input outs_t exp);
        checks++;
        assert (observed === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, exp);
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: check mid-cycle at the falling edge, then step past the rising edge.
    task automatic run_cycle(input string tag, input outs_t exp);
        @(negedge clock);
        checkOutput(tag, exp);
        @(posedge clock);
        #1;
        cur_cycles++;
    endtask

    // A memory handshake phase lasting until ready or until the wait limit aborts it.
    task automatic mem_phase(input string ph, input int w, output bit to);
        outs_t e;
        logic  rdy;
        to = 1'b0;
        for (int i = 0; i <= MAX_WAIT; i++) begin
            rdy = (i >= w);
            applyStimulus(rdy, opcode);
            e = phase_out(ph, rdy);
            if (!rdy && i == MAX_WAIT) begin
                e.mem_error = 1'b1;
                to = 1'b1;
            end
            run_cycle(ph, e);
            if (rdy || to) break;
        end
    endtask

    // Expands one instruction into phases, checking every cycle plus count and length.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wd);
        bit    to;
        bit    done;
        outs_t e;
        cur_cycles = 0;
        done = 1'b0;
        applyStimulus(1'b0, op);
        mem_phase("FETCH", wf, to);
        if (!to) begin
            applyStimulus(1'($urandom_range(0, 1)), op);
            e = phase_out("DECODE", 1'b0);
            e.illegal_op = !is_legal(op);
            run_cycle("DECODE", e);
            if (is_legal(op)) begin
                applyStimulus(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
                if (op == OP_LW || op == OP_SW) begin
                    run_cycle("MEM_ADDR", phase_out("MEM_ADDR", 1'b0));
                    if (op == OP_LW) begin
                        mem_phase("MEM_READ", wd, to);
                        if (!to) begin
                            applyStimulus(1'($urandom_range(0, 1)), opcode);
                            run_cycle("MEM_WB", phase_out("MEM_WB", 1'b0));
                            done = 1'b1;
                        end
                    end else begin
                        mem_phase("MEM_WRITE", wd, to);
                        done = !to;
                    end
                end else if (op == OP_RTYPE) begin
                    run_cycle("R_EXEC", phase_out("R_EXEC", 1'b0));
                    applyStimulus(1'($urandom_range(0, 1)), opcode);
                    run_cycle("R_WB", phase_out("R_WB", 1'b0));
                    done = 1'b1;
                end else if (op == OP_ADDI) begin
                    run_cycle("I_EXEC", phase_out("I_EXEC", 1'b0));
                    applyStimulus(1'($urandom_range(0, 1)), opcode);
                    run_cycle("I_WB", phase_out("I_WB", 1'b0));
                    done = 1'b1;
                end else if (op == OP_BEQ) begin
                    run_cycle("BRANCH", phase_out("BRANCH", 1'b0));
                    done = 1'b1;
                end else begin
                    run_cycle("JUMP", phase_out("JUMP", 1'b0));
                    done = 1'b1;
                end
            end
        end
        if (done) begin
            model_count = model_count + 32'd1;
            checkValue("latency", cur_cycles,
                       base_latency(op) + wf + ((op == OP_LW || op == OP_SW) ? wd : 0));
        end
        checkValue("retire_count", retire_count, model_count);
        seq_cycles += cur_cycles;
    endtask

    function automatic int rand_wait();
        if ($urandom_range(0, 3) == 0) return $urandom_range(13, 17);
        return $urandom_range(0, 2);
    endfunction

    function automatic logic [5:0] rand_op();
        logic [5:0] op;
        case ($urandom_range(0, 6))
            0: op = OP_LW;
            1: op = OP_SW;
            2: op = OP_RTYPE;
            3: op = OP_BEQ;
            4: op = OP_J;
            5: op = OP_ADDI;
            default: begin
                op = 6'($urandom_range(0, 63));
                while (is_legal(op)) op = 6'($urandom_range(0, 63));
            end
        endcase
        return op;
    endfunction

    // Directed scenarios, then a random instruction stream, then a mid-instruction reset.
    initial begin
        reset = 1'b0;
        applyStimulus(1'b1, OP_LW);
        #3;
        checkOutput("reset_outputs", '0);
        checkValue("reset_count", retire_count, 32'd0);
        @(posedge clock);
        #2;
        checkOutput("reset_held", '0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("fetch_after_release", phase_out("FETCH", 1'b1));

        run_instr(OP_LW, 0, 0);

        seq_cycles = 0;
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_ADDI, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_J, 0, 0);
        run_instr(OP_SW, 0, 0);
        checkValue("sequence_cycles", seq_cycles, 32'd18);

        run_instr(OP_LW, 0, 3);
        run_instr(OP_LW, MAX_WAIT + 1, 0);
        run_instr(OP_ADDI, MAX_WAIT, 0);
        run_instr(OP_LW, 0, MAX_WAIT);
        run_instr(OP_LW, 0, MAX_WAIT + 1);
        run_instr(OP_SW, 1, MAX_WAIT + 1);
        run_instr(OP_SW, 0, MAX_WAIT);
        run_instr(6'h3F, 0, 0);

        for (int n = 0; n < 40; n++)
            run_instr(rand_op(), rand_wait(), rand_wait());

        applyStimulus(1'b1, OP_SW);
        run_cycle("FETCH", phase_out("FETCH", 1'b1));
        run_cycle("DECODE", phase_out("DECODE", 1'b0));
        run_cycle("MEM_ADDR", phase_out("MEM_ADDR", 1'b0));
        applyStimulus(1'b0, OP_SW);
        run_cycle("MEM_WRITE", phase_out("MEM_WRITE", 1'b0));
        #1;
        checkOutput("mem_write_before_reset", phase_out("MEM_WRITE", 1'b0));
        reset = 1'b0;
        model_count = '0;
        #1;
        checkOutput("mid_reset_outputs", '0);
        checkValue("mid_reset_count", retire_count, model_count);
        @(posedge clock);
        #1;
        checkOutput("mid_reset_held", '0);
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, OP_J);
        #1;
        checkOutput("fetch_after_mid_reset", phase_out("FETCH", 1'b1));
        run_instr(OP_J, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
